// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm -- direct-mapped, read-only instruction cache
//
// Sits between the fetch stage and the instruction memory port. A hit
// returns the requested word in the same cycle. A miss stalls fetch
// (ready=0) while the whole 16-byte line is refilled from the backing
// memory, one word per mem_req/mem_valid handshake.
//
// Parameters
//   INDEX_BITS : log2 of the number of lines (each line holds 4 x 32-bit words)
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous, active-high reset
//   addr       in   byte address of the requested instruction
//   enable     in   request valid this cycle
//   flush      in   invalidate every line at the end of this cycle
//   data_out   out  instruction word, 32'h0 whenever ready=0
//   ready      out  data_out valid this cycle (hit)
//   err        out  misaligned request (addr[1:0] != 0 while enable=1)
//   mem_req    out  word read request to the backing memory
//   mem_addr   out  word-aligned address of the requested word
//   mem_valid  in   mem_data valid; completes the current mem_req
//   mem_data   in   returned word
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        enable,
    input  logic        flush,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [31:0]             base_q, base_d;        // line base being refilled
    logic [1:0]              cnt_q, cnt_d;          // refill beat counter
    logic                    discard_q, discard_d;  // flush seen during refill
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [TAG_W-1:0]        tag_d [LINES];
    logic [31:0]             data_q [LINES][4];
    logic [31:0]             data_d [LINES][4];
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;

    // ---------------------------------------------------------------------
    // Address decode for the lookup and for the line being refilled
    // ---------------------------------------------------------------------
    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [1:0]              req_off;
    logic                    aligned;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;

    assign req_off  = addr[3:2];
    assign req_idx  = addr[3+INDEX_BITS:4];
    assign req_tag  = addr[31:4+INDEX_BITS];
    assign aligned  = (addr[1:0] == 2'b00);
    assign fill_idx = base_q[3+INDEX_BITS:4];
    assign fill_tag = base_q[31:4+INDEX_BITS];

    // A flush in the same cycle suppresses the hit: the line is about to
    // be invalidated, and REFILL blocks every lookup until the line lands.
    assign hit = enable && aligned && (state_q == IDLE) && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag) && !flush;

    assign ready    = hit;
    assign data_out = hit ? data_q[req_idx][req_off] : 32'h0;
    assign err      = enable && !aligned;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;

        unique case (state_q)
            IDLE: begin
                if (enable && aligned && !hit && !flush) begin
                    state_d   = REFILL;
                    base_d    = {addr[31:4], 4'b0000};
                    cnt_d     = 2'd0;
                    discard_d = 1'b0;
                end
            end

            REFILL: begin
                // A flush anywhere in the refill, including the final beat,
                // keeps the line from being marked valid when it completes.
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (mem_valid) begin
                    data_d[fill_idx][cnt_q] = mem_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        if (!(discard_q || flush)) begin
                            valid_d[fill_idx] = 1'b1;
                            tag_d[fill_idx]   = fill_tag;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Flush invalidates everything, overriding a line completing now.
        if (flush) begin
            valid_d = '0;
        end

        // Memory request is registered: it reflects the state being entered.
        mem_req_d  = (state_d == REFILL);
        mem_addr_d = mem_req_d ? {base_d[31:4], cnt_d, 2'b00} : 32'h0;
    end

    // ---------------------------------------------------------------------
    // Control state with synchronous reset
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // flops update together from values sampled before the edge.
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= 32'h0;
            cnt_q      <= 2'd0;
            discard_q  <= 1'b0;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            discard_q  <= discard_d;
            valid_q    <= valid_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // ---------------------------------------------------------------------
    // Tag and data arrays
    // ---------------------------------------------------------------------
    // NOTE: the arrays are deliberately not reset; the valid bits gate every
    // use of them, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm -- self-checking bench for icache_dm
//
// Directed scenarios (cold miss, hits, conflict eviction, wait states,
// flush during refill, misaligned access, reset during refill) followed by
// randomized traffic. Expected outputs come from a line-level reference
// model of the cache (valid/tag/data per line plus an outstanding-refill
// record) that is advanced once per clock.
// ---------------------------------------------------------------------------
module tb_icache_dm;

    localparam int IB    = 4;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        enable;
    logic        flush;
    logic [31:0] data_out;
    logic        ready;
    logic        err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    icache_dm #(.INDEX_BITS(IB)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .enable    (enable),
        .flush     (flush),
        .data_out  (data_out),
        .ready     (ready),
        .err       (err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES][4];
    bit          m_busy;
    bit          m_discard;
    int unsigned m_base;
    int unsigned m_beat;
    bit          last_hit;

    // Random-phase variables
    int unsigned r_tag, r_idx, r_off, r_mis;
    bit          r_en, r_fl, r_mv, r_rst;
    int          k;

    // Backing memory contents: program words at the bottom, a hash elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            32'hC:   return 32'h0030_0193;
            default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_discard = 1'b0;
        m_base    = 0;
        m_beat    = 0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model across the following rising edge.
    task automatic tick(input bit en, input logic [31:0] a, input bit fl,
                        input bit mv, input bit r);
        bit          al;
        bit          hit;
        int unsigned idx;
        int unsigned tg;
        int unsigned bidx;
        logic [31:0] exp_data;
        logic [31:0] maddr;

        maddr = m_busy ? (m_base + 4 * m_beat) : 32'h0;
        @(negedge clk);
        rst       = r;
        enable    = en;
        addr      = a;
        flush     = fl;
        mem_valid = mv;
        mem_data  = mem_fn(maddr);
        #1;

        al       = (a[1:0] == 2'b00);
        idx      = (a >> 4) % LINES;
        tg       = a >> (4 + IB);
        hit      = en && al && !m_busy && m_valid[idx] && (m_tag[idx] == tg) && !fl;
        exp_data = hit ? m_data[idx][a[3:2]] : 32'h0;

        check("ready",    32'(ready),   32'(hit));
        check("data_out", data_out,     exp_data);
        check("err",      32'(err),     32'(en && !al));
        check("mem_req",  32'(mem_req), 32'(m_busy));
        if (m_busy) check("mem_addr", mem_addr, maddr);
        last_hit = hit;

        if (r) begin
            model_reset();
        end else begin
            if (!m_busy) begin
                if (en && al && !hit && !fl) begin
                    m_busy    = 1'b1;
                    m_base    = a & ~32'hF;
                    m_beat    = 0;
                    m_discard = 1'b0;
                end
            end else begin
                bidx = (m_base >> 4) % LINES;
                if (fl) m_discard = 1'b1;
                if (mv) begin
                    m_data[bidx][m_beat] = mem_fn(maddr);
                    if (m_beat == 3) begin
                        m_busy = 1'b0;
                        if (!m_discard) begin
                            m_valid[bidx] = 1'b1;
                            m_tag[bidx]   = m_base >> (4 + IB);
                        end
                    end else begin
                        m_beat++;
                    end
                end
            end
            if (fl) for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        end
    endtask

    // Miss on a line and refill it with zero-wait memory.
    task automatic fill_line(input logic [31:0] a);
        tick(1, a, 0, 0, 0);
        for (int b = 0; b < 4; b++) tick(1, a, 0, 1, 0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        addr      = 32'h0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_data  = 32'h0;
        model_reset();
        @(negedge clk);

        // Reset state
        tick(0, 32'h0, 0, 0, 1);
        tick(0, 32'h0, 0, 0, 0);
        check("reset_mem_addr", mem_addr, 32'h0);

        // Cold miss at 0x0, zero-wait memory
        fill_line(32'h0);
        tick(1, 32'h0, 0, 0, 0);
        check("cold_hit_data", data_out, 32'h0000_0013);

        // Hits on the rest of the line
        tick(1, 32'h4, 0, 0, 0);
        check("hit4_data", data_out, 32'h0010_0093);
        tick(1, 32'h8, 0, 0, 0);
        check("hit8_data", data_out, 32'h0020_0113);
        tick(1, 32'hC, 0, 0, 0);
        check("hitC_data", data_out, 32'h0030_0193);

        // mem_valid while idle is ignored
        tick(1, 32'h4, 0, 1, 0);
        tick(1, 32'h4, 0, 0, 0);

        // Conflict eviction: 0x100 maps to the same index as 0x0
        fill_line(32'h100);
        tick(1, 32'h104, 0, 0, 0);
        tick(1, 32'h0, 0, 0, 0);
        check("evict_miss_ready", 32'(ready), 32'h0);
        tick(1, 32'h0, 0, 1, 0);
        check("evict_refetch_addr", mem_addr, 32'h0);
        for (int b = 0; b < 3; b++) tick(1, 32'h0, 0, 1, 0);
        tick(1, 32'h0, 0, 0, 0);

        // Wait states: mem_valid on the fourth cycle of each beat
        tick(1, 32'h80, 0, 0, 0);
        k = 0;
        do begin
            tick(1, 32'h80, 0, (k % 4) == 3, 0);
            k++;
        end while (!last_hit && k < 100);
        check("wait_latency", 32'(k), 32'd17);

        // Flush during beat 2 of line 0x40
        tick(1, 32'h40, 0, 0, 0);
        tick(1, 32'h40, 0, 1, 0);
        tick(1, 32'h40, 1, 1, 0);
        tick(1, 32'h40, 0, 1, 0);
        tick(1, 32'h40, 0, 1, 0);
        tick(1, 32'h40, 0, 0, 0);
        check("flush_discard_miss", 32'(ready), 32'h0);
        tick(1, 32'h44, 0, 0, 0);
        check("flush_rerequest", mem_addr, 32'h40);
        for (int b = 0; b < 4; b++) tick(1, 32'h44, 0, 1, 0);
        tick(1, 32'h44, 0, 0, 0);

        // Flush in the final beat of line 0x50 also discards
        tick(1, 32'h50, 0, 0, 0);
        for (int b = 0; b < 3; b++) tick(1, 32'h50, 0, 1, 0);
        tick(1, 32'h50, 1, 1, 0);
        tick(1, 32'h50, 0, 0, 0);
        check("final_flush_miss", 32'(ready), 32'h0);
        for (int b = 0; b < 4; b++) tick(1, 32'h50, 0, 1, 0);

        // Misaligned access starts nothing
        tick(1, 32'h2, 0, 0, 0);
        check("misaligned_err", 32'(err), 32'h1);
        tick(1, 32'h2, 0, 0, 0);
        check("misaligned_no_req", 32'(mem_req), 32'h0);

        // Reset during beat 1 of a refill
        tick(1, 32'h30, 0, 0, 0);
        tick(1, 32'h30, 0, 1, 1);
        tick(0, 32'h0, 0, 0, 0);
        check("rst_abort_req", 32'(mem_req), 32'h0);
        check("rst_abort_addr", mem_addr, 32'h0);
        tick(1, 32'h0, 0, 0, 0);
        check("rst_cold_miss", 32'(ready), 32'h0);
        for (int b = 0; b < 4; b++) tick(1, 32'h0, 0, 1, 0);

        // Randomized traffic over a few tags so hits and conflicts both occur
        for (int n = 0; n < 1500; n++) begin
            r_tag = $urandom_range(0, 3);
            r_idx = $urandom_range(0, LINES - 1);
            r_off = $urandom_range(0, 3);
            r_mis = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0;
            r_en  = ($urandom_range(0, 9) != 0);
            r_fl  = ($urandom_range(0, 39) == 0);
            r_mv  = ($urandom_range(0, 9) < 6);
            r_rst = ($urandom_range(0, 199) == 0);
            tick(r_en, (r_tag << (4 + IB)) | (r_idx << 4) | (r_off << 2) | r_mis,
                 r_fl, r_mv, r_rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
